// File: rtl/laser_pack_pkg.sv
// laser_pack_pkg: shared state encoding, frame word tags and CRC helper for the laser frame packer.
package laser_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_POINTS,
        ST_TRAILER,
        ST_CRC
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;
    localparam logic [7:0]  TRL_MAGIC = 8'hC3;
    localparam logic [3:0]  PT_TAG    = 4'h1;
    localparam logic [15:0] CRC_MAGIC = 16'hC3C3;
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    // CRC-16/CCITT advanced over one 32-bit word, MSB first
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--)
            c = (c[15] ^ word[i]) ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/laser_pack_fifo.sv
// laser_pack_fifo: synchronous FIFO with a registered head word; level counts every stored word,
// including the one currently presented on rd_data.
module laser_pack_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic [AW:0]   level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   level_next;
    logic          wr, rd, bypass;

    assign full       = level == (AW+1)'(DEPTH);
    assign wr         = wr_en & !full;
    assign rd         = rd_ready & rd_valid;
    assign rd_next    = rd_ptr + AW'(rd);
    assign level_next = level + (AW+1)'(wr) - (AW+1)'(rd);
    // the incoming word becomes the head when nothing else remains after this cycle's read
    assign bypass     = (level - (AW+1)'(rd)) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr   <= rd_next;
            level    <= level_next;
            rd_valid <= level_next != '0;
            rd_data  <= bypass ? wr_data : mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/laser_frame_packer.sv
// laser_frame_packer: packs ranging samples into HDR/PT/TRL frame words and buffers them for the kernel.
// Define LASER_PACK_CRC_EN to append a {C3C3, crc16} word after each trailer.
module laser_frame_packer
    import laser_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_POINTS = 2048
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pack_en,
    input  logic                          scan_start,
    input  logic                          pt_valid,
    input  logic [15:0]                   pt_dist,
    output logic                          out_valid,
    output logic [31:0]                   out_data,
    input  logic                          out_ready,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    state_t      state;
    logic [15:0] frame_cnt, pt_idx;
    logic        ovf, full, wr_en, accept, drop, pt_room;
    logic [31:0] wr_data;
`ifdef LASER_PACK_CRC_EN
    logic [15:0] crc;
`endif

    assign pt_room = !full && (32'(pt_idx) < MAX_POINTS);
    assign accept  = wr_en & !full;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        drop    = 1'b0;
        case (state)
            ST_HEADER: begin
                wr_en   = 1'b1;
                wr_data = {HDR_MAGIC, frame_cnt};
                drop    = pt_valid;
            end
            ST_POINTS: begin
                wr_en   = pt_valid & pt_room;
                wr_data = {PT_TAG, pt_idx[11:0], pt_dist};
                drop    = pt_valid & !pt_room;
            end
            ST_TRAILER: begin
                wr_en   = 1'b1;
                wr_data = {TRL_MAGIC, ovf, 7'h0, pt_idx};
                drop    = pt_valid;
            end
`ifdef LASER_PACK_CRC_EN
            ST_CRC: begin
                wr_en   = 1'b1;
                wr_data = {CRC_MAGIC, crc};
                drop    = pt_valid;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            pt_idx    <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            case (state)
                ST_IDLE:
                    if (scan_start && pack_en) state <= ST_HEADER;
                ST_HEADER:
                    if (!full) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        pt_idx    <= '0;
                        ovf       <= 1'b0;
                        state     <= ST_POINTS;
                    end
                ST_POINTS: begin
                    if (accept) pt_idx <= pt_idx + 1'b1;
                    if (drop) ovf <= 1'b1;
                    if (scan_start || !pack_en) state <= ST_TRAILER;
                end
                ST_TRAILER:
`ifdef LASER_PACK_CRC_EN
                    if (!full) state <= ST_CRC;
                ST_CRC:
`endif
                    if (!full) state <= pack_en ? ST_HEADER : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LASER_PACK_CRC_EN
    // header restarts the checksum; every later accepted word of the frame extends it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc <= 16'hFFFF;
        else if (accept) crc <= crc16_word(state == ST_HEADER ? 16'hFFFF : crc, wr_data);
    end
`endif

    laser_pack_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .full     (full),
        .level    (fifo_level)
    );

endmodule
